// File: rtl/wb_port_arbiter.sv
// ---------------------------------------------------------------------------
// wb_port_arbiter
//   Shares one DATA_W-bit 4:1 mux feeding the downstream transfer port between
//   four producers. Picks a winner from req, locks it for a burst, and drives
//   sel / grant / out_valid. A burst ends on an accepted beat carrying last,
//   on the MAX_BEATS-th accepted beat, or when the owner drops its request.
//
// Parameters
//   DATA_W     width of each payload and of out_data
//   MAX_BEATS  accepted beats per burst before a forced release (1..256)
//
// Ports
//   clk, rst        rising-edge clock, synchronous active-high reset
//   req[3:0]        per-requester request, held until its burst ends
//   last[3:0]       per-requester end-of-burst, only the owner's bit matters
//   data0..data3    requester payloads
//   out_ready       downstream accepts the current beat
//   grant[3:0]      one-hot owner, zero when idle
//   sel[1:0]        mux select, holds the previous owner while idle
//   out_data        data[sel]
//   out_valid       a beat is present on out_data
//   busy            a grant is held
//
// Build option
//   WB_ARB_RR_EN    defined: round-robin arbitration starting at ptr.
//                   undefined: fixed priority req0 > req1 > req2 > req3.
// ---------------------------------------------------------------------------
module wb_port_arbiter #(
  parameter int DATA_W    = 32,
  parameter int MAX_BEATS = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        req,
  input  logic [3:0]        last,
  input  logic [DATA_W-1:0] data0,
  input  logic [DATA_W-1:0] data1,
  input  logic [DATA_W-1:0] data2,
  input  logic [DATA_W-1:0] data3,
  input  logic              out_ready,
  output logic [3:0]        grant,
  output logic [1:0]        sel,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              busy
);

  localparam int BEAT_W = $clog2(MAX_BEATS + 1);

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

  state_t            state, state_next;
  logic [1:0]        owner, owner_next;
  logic [BEAT_W-1:0] beats, beats_next;
  logic [1:0]        winner;
  logic              xfer;
  logic              at_limit;
  logic              do_release;

  // A beat moves only while we own the port and the owner still requests.
  // The limit check looks at the count before this beat, so the beat that
  // brings the count to MAX_BEATS is the one that forces the release.
  always_comb begin
    xfer       = (state == OWN) && req[owner] && out_ready;
    at_limit   = (beats == BEAT_W'(MAX_BEATS - 1));
    do_release = (state == OWN) &&
                 (!req[owner] || (xfer && (last[owner] || at_limit)));
  end

`ifdef WB_ARB_RR_EN
  logic [1:0] ptr, ptr_next;
  logic [1:0] idx;

  // Round-robin pick: scan ptr+3 down to ptr+0 so the candidate closest to
  // ptr is the last one written and therefore wins.
  always_comb begin
    winner = ptr;
    idx    = ptr;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (req[idx]) begin
        winner = idx;
      end
    end
  end

  // The pointer moves to the requester after the one just released, so
  // every release (normal, forced or abort) hands priority onward.
  always_comb begin
    ptr_next = ptr;
    if (do_release) begin
      ptr_next = owner + 2'd1;
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= 2'd0;
    end else begin
      ptr <= ptr_next;
    end
  end
`else
  // Fixed priority pick: lowest requesting index wins.
  always_comb begin
    winner = 2'd3;
    if (req[0]) begin
      winner = 2'd0;
    end else if (req[1]) begin
      winner = 2'd1;
    end else if (req[2]) begin
      winner = 2'd2;
    end
  end
`endif

  // Next-state logic. IDLE grabs a winner whenever anyone requests; OWN
  // counts accepted beats and drops back to IDLE on any release condition,
  // which gives exactly one idle cycle between bursts.
  always_comb begin
    state_next = state;
    owner_next = owner;
    beats_next = beats;
    case (state)
      IDLE: begin
        if (req != 4'b0000) begin
          state_next = OWN;
          owner_next = winner;
          beats_next = '0;
        end
      end
      OWN: begin
        if (do_release) begin
          state_next = IDLE;
          beats_next = '0;
        end else if (xfer) begin
          beats_next = beats + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State, owner and beat counter registers. The owner register doubles as
  // the mux select, so it keeps its value through IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      owner <= 2'd0;
      beats <= '0;
    end else begin
      state <= state_next;
      owner <= owner_next;
      beats <= beats_next;
    end
  end

  // Port-facing outputs. grant, sel and busy come straight from registers;
  // out_valid also follows the owner's live request.
  always_comb begin
    busy      = (state == OWN);
    sel       = owner;
    grant     = busy ? (4'b0001 << owner) : 4'b0000;
    out_valid = busy && req[owner];
  end

  // The shared 4:1 payload mux.
  always_comb begin
    out_data = data0;
    case (sel)
      2'd1:    out_data = data1;
      2'd2:    out_data = data2;
      2'd3:    out_data = data3;
      default: out_data = data0;
    endcase
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wb_port_arbiter
//   Self-checking bench for wb_port_arbiter. Every cycle the DUT outputs are
//   compared with a behavioural model that tracks owner / pointer / beat count
//   as plain integers. Directed bursts follow the intended use cases, then a
//   randomized stretch exercises aborts, resets and random back-pressure.
//   Honours WB_ARB_RR_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_wb_port_arbiter;

  localparam int DATA_W    = 32;
  localparam int MAX_BEATS = 16;

  logic              clk;
  logic              rst;
  logic [3:0]        req;
  logic [3:0]        last;
  logic [DATA_W-1:0] data0, data1, data2, data3;
  logic              out_ready;
  logic [3:0]        grant;
  logic [1:0]        sel;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              busy;

  wb_port_arbiter #(
    .DATA_W    (DATA_W),
    .MAX_BEATS (MAX_BEATS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .last      (last),
    .data0     (data0),
    .data1     (data1),
    .data2     (data2),
    .data3     (data3),
    .out_ready (out_ready),
    .grant     (grant),
    .sel       (sel),
    .out_data  (out_data),
    .out_valid (out_valid),
    .busy      (busy)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Behavioural model state: is a burst running, who owns it, where the
  // round-robin search starts, and how many beats were accepted so far.
  bit m_busy  = 1'b0;
  int m_owner = 0;
  int m_ptr   = 0;
  int m_beats = 0;

  bit        holdData  = 1'b0;
  int        xferCount = 0;
  int        beefCount = 0;
  logic [3:0] grantLog[$];
  logic [3:0] savedGrant;

  function automatic int pickWinner(logic [3:0] r);
`ifdef WB_ARB_RR_EN
    for (int off = 0; off < 4; off++) begin
      if (r[(m_ptr + off) % 4]) return (m_ptr + off) % 4;
    end
`else
    for (int i = 0; i < 4; i++) begin
      if (r[i]) return i;
    end
`endif
    return 0;
  endfunction

  function automatic logic [DATA_W-1:0] payloadOf(int i);
    case (i)
      1:       return data1;
      2:       return data2;
      3:       return data3;
      default: return data0;
    endcase
  endfunction

  task automatic checkOne(string tag, logic [31:0] got, logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Compare every DUT output against what the model predicts for the
  // current model state and the inputs now on the pins.
  task automatic checkOutput();
    logic [3:0] expGrant;
    logic       expValid;
    expGrant = m_busy ? 4'(1 << m_owner) : 4'b0000;
    expValid = m_busy && req[m_owner];
    checkOne("grant",     32'(grant),     32'(expGrant));
    checkOne("sel",       32'(sel),       32'(m_owner));
    checkOne("busy",      32'(busy),      32'(m_busy));
    checkOne("out_valid", 32'(out_valid), 32'(expValid));
    checkOne("out_data",  out_data,       payloadOf(m_owner));
    if (out_valid && out_ready) begin
      xferCount++;
      if (out_data == 32'hDEADBEEF) beefCount++;
    end
    if (busy) grantLog.push_back(grant);
  endtask

  // Advance the model by one clock edge using the spec's burst rules.
  task automatic modelStep();
    bit endBurst;
    endBurst = 1'b0;
    if (rst) begin
      m_busy  = 1'b0;
      m_owner = 0;
      m_ptr   = 0;
      m_beats = 0;
    end else if (!m_busy) begin
      if (req != 4'b0000) begin
        m_owner = pickWinner(req);
        m_busy  = 1'b1;
        m_beats = 0;
      end
    end else begin
      if (!req[m_owner]) begin
        endBurst = 1'b1;
      end else if (out_ready) begin
        m_beats++;
        if (last[m_owner] || m_beats == MAX_BEATS) endBurst = 1'b1;
      end
      if (endBurst) begin
        m_busy = 1'b0;
        m_ptr  = (m_owner + 1) % 4;
      end
    end
  endtask

  // Drive one cycle of inputs just after the falling edge, let them settle,
  // check outputs, then step the model for the coming rising edge.
  task automatic applyStimulus(logic r, logic [3:0] rq, logic [3:0] ls, logic rdy);
    @(negedge clk);
    rst       = r;
    req       = rq;
    last      = ls;
    out_ready = rdy;
    if (!holdData) begin
      data0 = $urandom;
      data1 = $urandom;
      data2 = $urandom;
      data3 = $urandom;
    end
    #1;
    checkOutput();
    modelStep();
  endtask

  initial begin
    rst = 1'b1; req = 4'b0000; last = 4'b0000; out_ready = 1'b0;
    data0 = '0; data1 = '0; data2 = '0; data3 = '0;

    // Reset, then a quiet bus for five cycles.
    applyStimulus(1'b1, 4'b0000, 4'b0000, 1'b1);
    applyStimulus(1'b1, 4'b0000, 4'b0000, 1'b1);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 4'b0000, 4'b0000, 1'b1);

    // Requester 2 sends three DEADBEEF beats, last on the third.
    $display("[TB] single burst on requester 2");
    holdData = 1'b1;
    data2    = 32'hDEADBEEF;
    beefCount = 0;
    applyStimulus(1'b0, 4'b0100, 4'b0000, 1'b1);
    applyStimulus(1'b0, 4'b0100, 4'b0000, 1'b1);
    applyStimulus(1'b0, 4'b0100, 4'b0000, 1'b1);
    applyStimulus(1'b0, 4'b0100, 4'b0100, 1'b1);
    applyStimulus(1'b0, 4'b0000, 4'b0000, 1'b1);
    applyStimulus(1'b0, 4'b0000, 4'b0000, 1'b1);
    checkOne("deadbeef_beats", 32'(beefCount), 32'd3);
    holdData = 1'b0;

    // All four request, every burst is a single beat with last.
    $display("[TB] all requesters, single-beat bursts");
    applyStimulus(1'b1, 4'b0000, 4'b0000, 1'b1);
    grantLog.delete();
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 4'b1111, 4'b1111, 1'b1);
    checkOne("grant_count", 32'(grantLog.size()), 32'd5);
    begin
`ifdef WB_ARB_RR_EN
      logic [3:0] expSeq[5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`else
      logic [3:0] expSeq[5] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`endif
      for (int i = 0; i < 5; i++) begin
        if (i < grantLog.size()) checkOne($sformatf("grant_seq%0d", i), 32'(grantLog[i]), 32'(expSeq[i]));
      end
    end

    // Requester 1 never signals last: forced release after MAX_BEATS beats,
    // then whoever the arbiter prefers among 1 and 3 takes over.
    $display("[TB] forced release at beat limit");
    applyStimulus(1'b1, 4'b0000, 4'b0000, 1'b1);
    xferCount  = 0;
    savedGrant = 4'b0000;
    for (int i = 0; i < 19; i++) begin
      applyStimulus(1'b0, 4'b1010, 4'b0000, 1'b1);
      if (i == 17) checkOne("idle_after_limit", 32'(busy), 32'd0);
      if (i == 18) savedGrant = grant;
      if (i == 17) checkOne("limit_beats", 32'(xferCount), 32'(MAX_BEATS));
    end
`ifdef WB_ARB_RR_EN
    checkOne("next_after_limit", 32'(savedGrant), 32'(4'b1000));
`else
    checkOne("next_after_limit", 32'(savedGrant), 32'(4'b0010));
`endif

    // Ready toggles during a four-beat burst from requester 0.
    $display("[TB] back-pressure during burst");
    applyStimulus(1'b1, 4'b0000, 4'b0000, 1'b1);
    xferCount = 0;
    applyStimulus(1'b0, 4'b0001, 4'b0000, 1'b0);
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b0, 4'b0001, (i == 6) ? 4'b0001 : 4'b0000, (i % 2) == 0);
    end
    applyStimulus(1'b0, 4'b0000, 4'b0000, 1'b1);
    checkOne("toggle_beats", 32'(xferCount), 32'd4);

    // Reset lands on the second beat of a burst, then requester 1 asks.
    $display("[TB] reset mid-burst");
    applyStimulus(1'b1, 4'b0000, 4'b0000, 1'b1);
    applyStimulus(1'b0, 4'b0100, 4'b0000, 1'b1);
    applyStimulus(1'b0, 4'b0100, 4'b0000, 1'b1);
    applyStimulus(1'b1, 4'b0100, 4'b0000, 1'b1);
    applyStimulus(1'b0, 4'b0010, 4'b0000, 1'b1);
    applyStimulus(1'b0, 4'b0010, 4'b0010, 1'b1);
    checkOne("grant_after_reset", 32'(grant), 32'(4'b0010));
    applyStimulus(1'b0, 4'b0000, 4'b0000, 1'b1);

    // Randomized traffic: random requests, last, ready and rare resets.
    $display("[TB] randomized traffic");
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 99) == 0,
                    4'($urandom),
                    ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000,
                    $urandom_range(0, 3) != 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
